// File: rtl/usb_cdc_pkg.sv
// Shared definitions for the USB CDC input path: report FSM states and the
// default debounce timing for a 48 MHz clock.
package usb_cdc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } report_state_e;

  localparam int unsigned DEFAULT_TICK_DIV       = 48000;
  localparam int unsigned DEFAULT_DEBOUNCE_TICKS = 5;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchroniser, tick-driven debounce counter and the
// accepted stable level. upd_o pulses in the cycle the stable level flips.
module debounce_bit
  import usb_cdc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic tick_i,
  input  logic pin_i,
  output logic stable_o,
  output logic upd_o
);

  localparam int unsigned           CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             sync;
  logic             upd;

  assign sync = sync_q[1];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sync_d   = {sync_q[0], pin_i};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    upd      = 1'b0;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync;
        cnt_d    = '0;
        upd      = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign upd_o    = upd;

endmodule

// File: rtl/input_debouncer.sv
// Debounces the raw input pins on a shared tick and reports each accepted
// change once through a valid/ready handshake with a sticky overrun flag.
module input_debouncer
  import usb_cdc_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TICK_DIV       = DEFAULT_TICK_DIV,
  parameter int unsigned DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] inputs_i,
  output logic [WIDTH-1:0] inputs_o,
  output logic             change_valid_o,
  input  logic             change_ready_i,
  output logic [WIDTH-1:0] change_data_o,
  output logic [WIDTH-1:0] change_mask_o,
  output logic             overrun_o
);

  localparam int unsigned      DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [WIDTH-1:0] stable, upd;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             overrun_q, overrun_d;
  logic             load;
  report_state_e    state_q, state_d;

  // Free-running prescaler shared by all bits.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_bit (
      .clk     (clk),
      .rstn_i  (rstn_i),
      .tick_i  (tick),
      .pin_i   (inputs_i[i]),
      .stable_o(stable[i]),
      .upd_o   (upd[i])
    );
  end

  // Report FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|pending_q)     state_d = HOLD;
      HOLD:    if (change_ready_i) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Report FSM: outputs. Valid is purely registered state, never a function of ready.
  always_comb begin
    change_valid_o = (state_q == HOLD);
  end

  // An upd in the load cycle goes straight into the loaded mask; stable ^ upd
  // is the level after this cycle's update.
  always_comb begin
    load      = (state_q == IDLE) && (|pending_q);
    pending_d = load ? '0 : (pending_q | upd);
    data_d    = load ? (stable ^ upd) : data_q;
    mask_d    = load ? (pending_q | upd) : mask_q;
    overrun_d = overrun_q | (|(pending_q & upd));
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      div_q     <= '0;
      state_q   <= IDLE;
      pending_q <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
    end
  end

  assign inputs_o      = stable;
  assign change_data_o = data_q;
  assign change_mask_o = mask_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with a small tick/debounce timing
// and a behavioural reference model driven in lock-step with the DUT.
module tb_input_debouncer;

  localparam int W  = 8;
  localparam int TD = 4;
  localparam int DT = 3;

  logic         clk;
  logic         rstn_i;
  logic [W-1:0] inputs_i;
  logic [W-1:0] inputs_o;
  logic         change_valid_o;
  logic         change_ready_i;
  logic [W-1:0] change_data_o;
  logic [W-1:0] change_mask_o;
  logic         overrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  input_debouncer #(
    .WIDTH         (W),
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk           (clk),
    .rstn_i        (rstn_i),
    .inputs_i      (inputs_i),
    .inputs_o      (inputs_o),
    .change_valid_o(change_valid_o),
    .change_ready_i(change_ready_i),
    .change_data_o (change_data_o),
    .change_mask_o (change_mask_o),
    .overrun_o     (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state. Debounce is expressed as "ticks elapsed since the
  // bit last agreed with its stable level", counted arithmetically.
  int           m_cyc;
  logic [W-1:0] m_s1, m_s2, m_stable, m_pending, m_data, m_mask;
  logic         m_hold, m_overrun;
  int           m_la [W];

  function automatic int nticks(input int upto);
    return (upto + 1) / TD;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_s1 = '0; m_s2 = '0; m_stable = '0; m_pending = '0;
    m_data = '0; m_mask = '0; m_hold = 1'b0; m_overrun = 1'b0;
    for (int i = 0; i < W; i++) m_la[i] = -1;
  endtask

  task automatic model_step(input logic [W-1:0] in, input logic rdy);
    logic [W-1:0] upd;
    logic [W-1:0] nstable;
    bit           tick;
    tick = (m_cyc % TD) == TD - 1;
    upd  = '0;
    for (int i = 0; i < W; i++) begin
      if (m_s2[i] == m_stable[i]) m_la[i] = m_cyc;
      else if (tick && (nticks(m_cyc - 1) - nticks(m_la[i]) == DT - 1)) begin
        upd[i]  = 1'b1;
        m_la[i] = m_cyc;
      end
    end
    nstable   = m_stable ^ upd;
    m_overrun = m_overrun | (|(m_pending & upd));
    if (!m_hold && m_pending != '0) begin
      m_data    = nstable;
      m_mask    = m_pending | upd;
      m_pending = '0;
      m_hold    = 1'b1;
    end else begin
      m_pending = m_pending | upd;
      if (m_hold && rdy) m_hold = 1'b0;
    end
    m_stable = nstable;
    m_s2     = m_s1;
    m_s1     = in;
    m_cyc++;
  endtask

  // All tasks start and end just after a falling edge.
  task automatic step(input logic [W-1:0] in, input logic rdy);
    inputs_i       = in;
    change_ready_i = rdy;
    @(posedge clk);
    model_step(in, rdy);
    @(negedge clk);
  endtask

  task automatic assert_reset(input logic [W-1:0] in);
    #2;
    rstn_i         = 1'b0;
    inputs_i       = in;
    change_ready_i = 1'b0;
    model_reset();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic wait_stable(input logic [W-1:0] in, input logic [W-1:0] target,
                             input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      step(in, 1'b0);
      if (inputs_o === target) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(input logic [W-1:0] in, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      step(in, 1'b0);
      if (change_valid_o === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    assert_reset(8'hFF);
    #1;
    n_checks++;
    if ({inputs_o, change_valid_o, change_data_o, change_mask_o, overrun_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got in=%h v=%b d=%h m=%h o=%b, want all 0",
               inputs_o, change_valid_o, change_data_o, change_mask_o, overrun_o);
    end
    release_reset();
    wait_stable(8'hFF, 8'hFF, 15, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_latency: inputs_o=%h, want ff within 15 cycles", inputs_o);
    end
    step(8'hFF, 1'b0);
    n_checks++;
    if (change_valid_o !== 1'b1 || change_data_o !== 8'hFF || change_mask_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_first_report: v=%b d=%h m=%h, want v=1 d=ff m=ff",
               change_valid_o, change_data_o, change_mask_o);
    end
  endtask

  task automatic test_single_bit();
    bit ok;
    assert_reset(8'h00);
    release_reset();
    repeat (3) step(8'h00, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 15 && !ok; k++) begin
      step(8'h01, 1'b1);
      if (inputs_o === 8'h01) ok = 1'b1;
    end
    n_checks++;
    if (!ok || change_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: inputs_o=%h v=%b, want 01 with v=0", inputs_o, change_valid_o);
    end
    step(8'h01, 1'b1);
    n_checks++;
    if (change_valid_o !== 1'b1 || change_data_o !== 8'h01 || change_mask_o !== 8'h01) begin
      n_fail++;
      $display("FAIL single_report: v=%b d=%h m=%h, want v=1 d=01 m=01",
               change_valid_o, change_data_o, change_mask_o);
    end
    step(8'h01, 1'b1);
    n_checks++;
    if (change_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_one_cycle: v=%b, want 0", change_valid_o);
    end
  endtask

  task automatic test_glitch();
    bit saw_valid = 1'b0;
    assert_reset(8'h00);
    release_reset();
    repeat (2) step(8'h00, 1'b1);
    repeat (6) begin
      step(8'h04, 1'b1);
      if (change_valid_o === 1'b1 || inputs_o !== 8'h00) saw_valid = 1'b1;
    end
    repeat (20) begin
      step(8'h00, 1'b1);
      if (change_valid_o === 1'b1 || inputs_o !== 8'h00) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid) begin
      n_fail++;
      $display("FAIL glitch_rejected: short pulse on bit2 was accepted, inputs_o=%h", inputs_o);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    assert_reset(8'h00);
    release_reset();
    wait_valid(8'h01, 20, ok);
    n_checks++;
    if (!ok || change_data_o !== 8'h01 || change_mask_o !== 8'h01) begin
      n_fail++;
      $display("FAIL bp_first: ok=%b d=%h m=%h, want ok=1 d=01 m=01", ok, change_data_o, change_mask_o);
    end
    repeat (18) step(8'h09, 1'b0);
    n_checks++;
    if (change_valid_o !== 1'b1 || change_mask_o !== 8'h01 || inputs_o !== 8'h09) begin
      n_fail++;
      $display("FAIL bp_frozen: v=%b m=%h in=%h, want v=1 m=01 in=09",
               change_valid_o, change_mask_o, inputs_o);
    end
    step(8'h09, 1'b1);
    n_checks++;
    if (change_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_gap: v=%b, want 0 after transfer", change_valid_o);
    end
    step(8'h09, 1'b0);
    n_checks++;
    if (change_valid_o !== 1'b1 || change_data_o !== 8'h09 || change_mask_o !== 8'h08) begin
      n_fail++;
      $display("FAIL bp_second: v=%b d=%h m=%h, want v=1 d=09 m=08",
               change_valid_o, change_data_o, change_mask_o);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    assert_reset(8'h00);
    release_reset();
    wait_valid(8'h20, 20, ok);
    repeat (18) step(8'h00, 1'b0);
    n_checks++;
    if (!ok || overrun_o !== 1'b0 || inputs_o !== 8'h00) begin
      n_fail++;
      $display("FAIL ovr_first_toggle: ok=%b ovr=%b in=%h, want ok=1 ovr=0 in=00", ok, overrun_o, inputs_o);
    end
    repeat (18) step(8'h20, 1'b0);
    n_checks++;
    if (overrun_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flag: overrun_o=%b, want 1", overrun_o);
    end
    step(8'h20, 1'b1);
    step(8'h20, 1'b0);
    n_checks++;
    if (change_valid_o !== 1'b1 || change_mask_o !== 8'h20 || change_data_o !== 8'h20) begin
      n_fail++;
      $display("FAIL ovr_second_report: v=%b d=%h m=%h, want v=1 d=20 m=20",
               change_valid_o, change_data_o, change_mask_o);
    end
  endtask

  task automatic test_mid_hold_reset();
    bit ok;
    int stale = 0;
    assert_reset(8'h00);
    release_reset();
    wait_valid(8'h10, 20, ok);
    assert_reset(8'h00);
    #1;
    n_checks++;
    if (!ok || change_valid_o !== 1'b0 || change_data_o !== 8'h00 || change_mask_o !== 8'h00) begin
      n_fail++;
      $display("FAIL hold_reset_async: ok=%b v=%b d=%h m=%h, want ok=1 v=0 d=00 m=00",
               ok, change_valid_o, change_data_o, change_mask_o);
    end
    release_reset();
    repeat (30) begin
      step(8'h00, 1'b1);
      if (change_valid_o !== 1'b0) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL hold_reset_stale: valid high %0d cycles after reset, want 0", stale);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] cur = '0;
    int           hold_left = 0;
    logic         rdy;
    assert_reset(8'h00);
    release_reset();
    for (int c = 0; c < 1500; c++) begin
      if (hold_left == 0) begin
        cur = cur ^ W'(1 << $urandom_range(0, W - 1));
        if ($urandom_range(0, 3) == 0) cur = cur ^ W'(1 << $urandom_range(0, W - 1));
        hold_left = $urandom_range(1, 22);
      end
      hold_left--;
      rdy = ($urandom_range(0, 3) != 0);
      step(cur, rdy);
      n_checks++;
      if (inputs_o !== m_stable) begin
        n_fail++;
        $display("FAIL rnd_inputs cyc %0d: got %h want %h", m_cyc, inputs_o, m_stable);
      end
      n_checks++;
      if (change_valid_o !== m_hold) begin
        n_fail++;
        $display("FAIL rnd_valid cyc %0d: got %b want %b", m_cyc, change_valid_o, m_hold);
      end
      n_checks++;
      if (change_data_o !== m_data || change_mask_o !== m_mask) begin
        n_fail++;
        $display("FAIL rnd_report cyc %0d: got d=%h m=%h want d=%h m=%h",
                 m_cyc, change_data_o, change_mask_o, m_data, m_mask);
      end
      n_checks++;
      if (overrun_o !== m_overrun) begin
        n_fail++;
        $display("FAIL rnd_overrun cyc %0d: got %b want %b", m_cyc, overrun_o, m_overrun);
      end
    end
  endtask

  initial begin
    rstn_i         = 1'b0;
    inputs_i       = '0;
    change_ready_i = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_bit();
    test_glitch();
    test_backpressure();
    test_overrun();
    test_mid_hold_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
